// File: rtl/matrix_acc_pkg.sv
`default_nettype none
// =============================================================================
// matrix_acc_pkg : matrix_mul control codes and matrix_acc state encodings.
// Rev 1.0
// =============================================================================
package matrix_acc_pkg;

  localparam logic [3:0] MATRIX_IDLE = 4'h0;
  localparam logic [3:0] MATRIX_MUL  = 4'h1;

  localparam logic [1:0] MACC_IDLE  = 2'd0;
  localparam logic [1:0] MACC_ACCUM = 2'd1;
  localparam logic [1:0] MACC_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = MACC_IDLE,
    ST_ACCUM = MACC_ACCUM,
    ST_DRAIN = MACC_DRAIN
  } macc_state_e;

endpackage
`default_nettype wire

// File: rtl/matrix_acc.sv
`default_nettype none
// =============================================================================
// matrix_acc : 4x4 byte accumulator tile controller sitting upstream of
//              matrix_mul; MATRIX_ACC_KEEP_EN adds acc_keep_i (tile chaining).
// Rev 1.0
// =============================================================================
module matrix_acc
  import matrix_acc_pkg::*;
#(
  parameter int K_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [K_W-1:0] k_len_i,
`ifdef MATRIX_ACC_KEEP_EN
  input  logic           acc_keep_i,
`endif
  input  logic           op_valid_i,
  output logic           op_ready_o,
  input  logic [31:0]    op_a_i,
  input  logic [31:0]    op_b_i,
  output logic [3:0]     mul_ctrl_o,
  output logic [31:0]    op_A_o,
  output logic [31:0]    op_B_o,
  output logic [31:0]    M_o [3:0],
  input  logic [31:0]    matrix_mul_i [3:0],
  output logic           row_valid_o,
  input  logic           row_ready_i,
  output logic [31:0]    row_data_o,
  output logic [1:0]     row_idx_o,
  output logic           row_last_o,
  output logic           busy_o,
  output logic           done_o
);

  macc_state_e    r_state;
  logic [31:0]    r_tile [3:0];
  logic [K_W-1:0] r_k_cnt;
  logic [1:0]     r_row_idx;
  logic           r_done;
  logic           w_keep;
  logic           w_fire;

`ifdef MATRIX_ACC_KEEP_EN
  assign w_keep = acc_keep_i;
`else
  assign w_keep = 1'b0;
`endif

  // matrix_mul is combinational beside us: operands go out in the fire cycle
  // and its result is captured into the tile at the closing edge.
  assign w_fire     = (r_state == ST_ACCUM) & op_valid_i;
  assign mul_ctrl_o = w_fire ? MATRIX_MUL : MATRIX_IDLE;
  assign op_A_o     = w_fire ? op_a_i : '0;
  assign op_B_o     = w_fire ? op_b_i : '0;

  assign op_ready_o  = (r_state == ST_ACCUM);
  assign row_valid_o = (r_state == ST_DRAIN);
  assign row_data_o  = (r_state == ST_DRAIN) ? r_tile[r_row_idx] : '0;
  assign row_idx_o   = r_row_idx;
  assign row_last_o  = (r_state == ST_DRAIN) & (r_row_idx == 2'd3);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign M_o         = r_tile;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_k_cnt   <= '0;
      r_row_idx <= 2'd0;
      r_done    <= 1'b0;
      for (int i = 0; i < 4; i++) r_tile[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_k_cnt   <= k_len_i;
            r_row_idx <= 2'd0;
            if (!w_keep) begin
              for (int i = 0; i < 4; i++) r_tile[i] <= '0;
            end
            r_state <= (k_len_i == '0) ? ST_DRAIN : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (op_valid_i) begin
            r_tile  <= matrix_mul_i;
            r_k_cnt <= r_k_cnt - 1'b1;
            if (r_k_cnt == K_W'(1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (row_ready_i) begin
            r_row_idx <= r_row_idx + 2'd1;
            if (r_row_idx == 2'd3) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_acc.sv
`default_nettype none
// =============================================================================
// tb_matrix_acc : randomized bench for matrix_acc against a byte-level tile
//                 model, plus literal expectations from hand-worked cases.
// Rev 1.0
// =============================================================================
module tb_matrix_acc;
  import matrix_acc_pkg::*;

  localparam int K_W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_i = 1'b0;
  logic [K_W-1:0] k_len_i = '0;
`ifdef MATRIX_ACC_KEEP_EN
  logic           acc_keep_i = 1'b0;
`endif
  logic           op_valid_i = 1'b0;
  logic           op_ready_o;
  logic [31:0]    op_a_i = '0;
  logic [31:0]    op_b_i = '0;
  logic [3:0]     mul_ctrl_o;
  logic [31:0]    op_A_o, op_B_o;
  logic [31:0]    M_o [3:0];
  logic [31:0]    mm [3:0];
  logic           row_valid_o;
  logic           row_ready_i = 1'b0;
  logic [31:0]    row_data_o;
  logic [1:0]     row_idx_o;
  logic           row_last_o;
  logic           busy_o;
  logic           done_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  logic [31:0] qa[$], qb[$], got[$];

  matrix_acc #(.K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .k_len_i(k_len_i),
`ifdef MATRIX_ACC_KEEP_EN
    .acc_keep_i(acc_keep_i),
`endif
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .mul_ctrl_o(mul_ctrl_o),
    .op_A_o(op_A_o), .op_B_o(op_B_o), .M_o(M_o), .matrix_mul_i(mm),
    .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .row_data_o(row_data_o), .row_idx_o(row_idx_o), .row_last_o(row_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stand-in for matrix_mul: row i lane j = M + A[j]*B[i]; junk when idle so a
  // tile load outside a fire shows up.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mm[i] = 32'h5AA5_C33C + i;
      if (mul_ctrl_o == MATRIX_MUL)
        for (int j = 0; j < 4; j++)
          mm[i][8*j +: 8] = M_o[i][8*j +: 8] + op_A_o[8*j +: 8] * op_B_o[8*i +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 collecting pairs, 2 draining rows.
  logic [7:0] m_t [4][4];
  int         m_phase, m_k, m_row;
  bit         m_done;
  logic       keep_in;
`ifdef MATRIX_ACC_KEEP_EN
  assign keep_in = acc_keep_i;
`else
  assign keep_in = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m_t[i][j] = 8'd0;
      m_phase = 0; m_k = 0; m_row = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (start_i) begin
          m_k = int'(k_len_i);
          if (!keep_in)
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m_t[i][j] = 8'd0;
          m_row = 0;
          m_phase = (m_k == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (op_valid_i) begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              m_t[i][j] = m_t[i][j] + op_a_i[8*j +: 8] * op_b_i[8*i +: 8];
          m_k--;
          if (m_k == 0) m_phase = 2;
        end
      end else if (row_ready_i) begin
        if (m_row == 3) begin m_phase = 0; m_row = 0; m_done = 1'b1; end
        else m_row++;
      end
    end
  end

  always @(negedge clk) begin
    bit fire;
    if (chk_en) begin
      fire = (m_phase == 1) && op_valid_i;
      chk("busy", 32'(busy_o), 32'(m_phase != 0));
      chk("op_ready", 32'(op_ready_o), 32'(m_phase == 1));
      chk("row_valid", 32'(row_valid_o), 32'(m_phase == 2));
      chk("mul_ctrl", 32'(mul_ctrl_o), 32'(fire ? MATRIX_MUL : MATRIX_IDLE));
      chk("op_A", op_A_o, fire ? op_a_i : 32'd0);
      chk("op_B", op_B_o, fire ? op_b_i : 32'd0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("M_o[%0d]", i), M_o[i], {m_t[i][3], m_t[i][2], m_t[i][1], m_t[i][0]});
      chk("done", 32'(done_o), 32'(m_done));
      if (m_phase == 2) begin
        chk("row_idx", 32'(row_idx_o), m_row);
        chk("row_data", row_data_o, {m_t[m_row][3], m_t[m_row][2], m_t[m_row][1], m_t[m_row][0]});
        chk("row_last", 32'(row_last_o), 32'(m_row == 3));
        if (row_valid_o && row_ready_i) got.push_back(row_data_o);
      end
      if (done_o) done_cnt++;
    end
  end

  // One tile operation using pairs from qa/qb. lat = edges from start edge to done.
  task automatic do_op(input int k, input bit keep, input int glo, input int ghi,
                       input int rpct, input bit stall1, input bit noise, output int lat);
    int s, stalls, gap;
    bit rdy;
    got.delete();
    @(posedge clk); #1;
    start_i = 1'b1; k_len_i = K_W'(k);
`ifdef MATRIX_ACC_KEEP_EN
    acc_keep_i = keep;
`endif
    op_valid_i = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    @(posedge clk); #1;
    s = cyc; start_i = 1'b0;
    for (int p = 0; p < k; p++) begin
      gap = $urandom_range(ghi, glo);
      for (int g = 0; g < gap; g++) begin
        op_valid_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom;
        @(posedge clk); #1;
      end
      op_valid_i = 1'b1; op_a_i = qa[p]; op_b_i = qb[p];
      @(posedge clk); #1;
    end
    op_valid_i = 1'b0;
    lat = -1; stalls = 0;
    for (int c = 0; c < 200; c++) begin
      rdy = ($urandom_range(99, 0) < rpct);
      if (stall1 && row_valid_o && row_idx_o == 2'd1 && stalls < 3) begin
        rdy = 1'b0; stalls++;
      end
      row_ready_i = rdy;
      start_i = 1'b0;
      // start pulses while draining must be ignored; never on the leaving edge
      if (noise && row_valid_o && (row_idx_o != 2'd3 || !rdy) && $urandom_range(3, 0) == 0) begin
        start_i = 1'b1; k_len_i = K_W'($urandom_range(15, 0));
      end
      op_valid_i = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      op_a_i = $urandom; op_b_i = $urandom;
      @(posedge clk); #1;
      if (done_o) begin lat = cyc - s; break; end
    end
    row_ready_i = 1'b0; start_i = 1'b0; op_valid_i = 1'b0;
    chk("drain_completes", 32'(lat >= 0), 32'd1);
  endtask

  task automatic chk_rows(input string nm, input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
    logic [31:0] e [4];
    e = '{r0, r1, r2, r3};
    chk({nm, "_count"}, got.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_row%0d", nm, i), (i < got.size()) ? got[i] : 32'hxxxx_xxxx, e[i]);
  endtask

  task automatic set_pairs(input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1);
    qa = '{a0, a1};
    qb = '{b0, b1};
  endtask

  initial begin
    int lat, k;
    bit keep;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mul_ctrl", 32'(mul_ctrl_o), 32'(MATRIX_IDLE));
    chk("rst_op_ready", 32'(op_ready_o), 32'd0);
    chk("rst_row_valid", 32'(row_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_row_idx", 32'(row_idx_o), 32'd0);
    chk("rst_row_data", row_data_o, 32'd0);
    chk("rst_row_last", 32'(row_last_o), 32'd0);
    chk("rst_op_A", op_A_o, 32'd0);
    chk("rst_M_o3", M_o[3], 32'd0);
    @(posedge clk); #2 rst = 1'b0; chk_en = 1'b1;

    // Single step: B lanes all 1 so every row equals A; done in cycle t+6.
    set_pairs(32'h04030201, 32'h01010101, 32'h0, 32'h0);
    do_op(1, 1'b0, 0, 0, 100, 1'b0, 1'b0, lat);
    chk_rows("single", 32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201);
    chk("single_done_latency", lat, 32'd5);
`ifdef MATRIX_ACC_KEEP_EN
    do_op(1, 1'b1, 0, 0, 100, 1'b0, 1'b0, lat);
    chk_rows("keep", 32'h08060402, 32'h08060402, 32'h08060402, 32'h08060402);
`endif

    set_pairs(32'h01010101, 32'h01020304, 32'h01010101, 32'h01020304);
    do_op(2, 1'b0, 0, 0, 100, 1'b0, 1'b0, lat);
    chk_rows("two", 32'h08080808, 32'h06060606, 32'h04040404, 32'h02020202);

    set_pairs(32'h000000FF, 32'h00000002, 32'h0, 32'h0);
    do_op(1, 1'b0, 0, 0, 100, 1'b0, 1'b0, lat);
    chk_rows("wrap", 32'h000000FE, 32'h0, 32'h0, 32'h0);

    set_pairs(32'h01010101, 32'h01020304, 32'h01010101, 32'h01020304);
    do_op(2, 1'b0, 2, 2, 100, 1'b0, 1'b0, lat);
    chk_rows("gapped", 32'h08080808, 32'h06060606, 32'h04040404, 32'h02020202);

    do_op(2, 1'b0, 0, 0, 100, 1'b1, 1'b0, lat);
    chk_rows("stall_row1", 32'h08080808, 32'h06060606, 32'h04040404, 32'h02020202);

    do_op(0, 1'b0, 0, 0, 60, 1'b0, 1'b1, lat);
    chk_rows("k0", 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset in the middle of an accumulation.
    @(posedge clk); #1 start_i = 1'b1; k_len_i = K_W'(3);
    @(posedge clk); #1 start_i = 1'b0; op_valid_i = 1'b1;
    op_a_i = 32'h01010101; op_b_i = 32'h01010101;
    @(posedge clk); #1 op_valid_i = 1'b0;
    chk("rst_pre_tile", M_o[2], 32'h01010101);
    done_cnt = 0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_mid_M_o%0d", i), M_o[i], 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_no_done", done_cnt, 32'd0);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(15, 0);
      keep = 1'($urandom_range(1, 0));
      qa.delete(); qb.delete();
      for (int p = 0; p < k; p++) begin
        qa.push_back($urandom);
        qb.push_back($urandom);
      end
      do_op(k, keep, 0, 2, $urandom_range(100, 50), 1'($urandom_range(1, 0)), 1'b1, lat);
      chk("rand_rows", got.size(), 32'd4);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/matrix_acc.md
# matrix_acc

Accumulator-tile controller that sits directly upstream of `matrix_mul`. It owns the 4×4 byte accumulator tile `M`, sequences K outer-product steps by streaming `op_A`/`op_B` pairs into `matrix_mul`, and registers each product back into the tile. When the steps are done, it drains the four tile rows to the writeback side over a valid/ready handshake.

## Interface
Parameters:
- `K_W`, default 4: width of the step count; K ranges from 0 to 2^K_W−1.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  starts a tile operation; sampled only in IDLE.
- `k_len_i`  in  K_W  number of operand pairs to accumulate; sampled with `start_i`.
- `op_valid_i` / `op_ready_o`  in/out  1  operand-pair handshake.
- `op_a_i`, `op_b_i`  in  32  packed byte operands (4 lanes).
- `mul_ctrl_o`  out  4  to `matrix_mul` `mul_ctrl`.
- `op_A_o`, `op_B_o`  out  32  to `matrix_mul` operands.
- `M_o[3:0]`  out  32 each  current tile, fed to `matrix_mul` `M`.
- `matrix_mul_i[3:0]`  in  32 each  result from `matrix_mul_o`.
- `row_valid_o` / `row_ready_i`  out/in  1  drain handshake.
- `row_data_o`  out  32  tile row being drained.
- `row_idx_o`  out  2  index of the row on `row_data_o`.
- `row_last_o`  out  1  high while row 3 is presented.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse when an operation completes.

## Operation
States: IDLE, ACCUM, DRAIN.

- **IDLE**
  - `op_ready_o` and `row_valid_o` are 0.
  - On `start_i`: latch `k_len_i` into `k_cnt`, clear the tile (see Configuration), and move to ACCUM, or straight to DRAIN if `k_len_i`=0.
- **ACCUM**
  - `op_ready_o`=1. A fire is `op_valid_i & op_ready_o`.
  - On a fire: `mul_ctrl_o`=`` `MATRIX_MUL``, `op_A_o`=`op_a_i`, `op_B_o`=`op_b_i`; at the same edge the tile takes `matrix_mul_i[*]` and `k_cnt` decrements.
  - On a non-fire cycle: `mul_ctrl_o`=`` `MATRIX_IDLE``, operands are 0, and the tile holds.
  - The fire that takes `k_cnt` from 1 to 0 moves the state to DRAIN.
- **DRAIN**
  - `row_valid_o`=1; `row_data_o`=tile[`row_idx_o`].
  - `row_idx_o` advances 0→3, one step per `row_ready_i` handshake.
  - The handshake on row 3 moves the state to IDLE and pulses `done_o`.
- Arithmetic is defined entirely by `matrix_mul`: each byte lane computes M + a·b modulo 256 (wraps, no saturation). This block adds no arithmetic.
- `start_i` outside IDLE is ignored. `op_valid_i` outside ACCUM is not acknowledged.
- `M_o` is the registered tile at all times.

## Timing
- Reset values:
  - state=IDLE, tile=0, `k_cnt`=0, `row_idx_o`=0.
  - All outputs are 0, except `mul_ctrl_o`=`` `MATRIX_IDLE``.
- `start_i` at edge t puts the block in ACCUM from cycle t+1.
- With no stalls, K pairs take K cycles and the drain takes 4 cycles. `done_o` is high in the cycle after the row-3 handshake, so one operation costs 1+K+4 cycles plus `done_o`.
- Each fire has a one-cycle update path: the tile is updated at the end of the fire cycle, and the next pair sees the updated `M_o`.
- While `row_ready_i`=0, `row_data_o`, `row_idx_o` and `row_last_o` hold stable.
- Asserting `rst` in any state returns the block to IDLE with the tile zeroed immediately (asynchronous). The partial tile is discarded and `done_o` does not pulse.

## Configuration
- `MATRIX_ACC_KEEP_EN` defined:
  - Adds input port `acc_keep_i` (1 bit), sampled with `start_i`.
  - If 1, the tile is not cleared at start, so a run continues the previous tile. This allows chaining K beyond 2^K_W−1.
- `MATRIX_ACC_KEEP_EN` undefined:
  - The port is absent and every start clears the tile.

## Structure
- `define.vh` gains `MATRIX_IDLE` (a 4-bit code distinct from `MATRIX_MUL`) and the state encodings `MACC_IDLE`, `MACC_ACCUM`, `MACC_DRAIN`.
- No sub-module. `matrix_mul` is instantiated beside this block by the parent, not inside it.

## Test plan
- **Single step:** K=1, A=0x04030201, B=0x01010101 → rows 0–3 all drain as 0x04030201; `done_o` pulses at cycle 6 after start.
- **Two steps:** K=2, two pairs of A=0x01010101, B=0x01020304 → rows 0..3 = 0x08080808, 0x06060606, 0x04040404, 0x02020202.
- **Lane wrap:** K=1, A=0x000000FF, B=0x00000002 → row 0 = 0x000000FE; rows 1–3 = 0.
- **Stalls:**
  - `op_valid_i` gapped for 2 cycles between pairs → same tile as the two-step case, `mul_ctrl_o`=`` `MATRIX_IDLE`` during the gaps.
  - `row_ready_i` low for 3 cycles on row 1 → row 1 data and index stable, no skipped or duplicated rows.
- **K=0 and ignored start:** K=0 → four zero rows drained immediately. `start_i` asserted during DRAIN → ignored.
- **Reset and chaining:**
  - `rst` pulsed mid-ACCUM after one pair → IDLE, `M_o`=0, no `done_o`.
  - With `MATRIX_ACC_KEEP_EN`: repeat the single-step case with `acc_keep_i`=1 → rows drain as 0x08060402.
